// File: rtl/mem_lane_unit_pkg.sv
// Shared definitions for the data-memory lane unit: widths, size codes, FSM states.
// Latency: none (declarations and a pure combinational helper).
// Backpressure: not applicable.
package mem_lane_unit_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Misaligned half/word or the reserved size code: never reaches the memory.
  function automatic logic req_err(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: req_err = 1'b0;
      SIZE_HALF: req_err = off[0];
      SIZE_WORD: req_err = (off != 2'b00);
      default:   req_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_unit_if.sv
// Pipeline request/response plus data-memory bus of the lane unit.
// Latency: none (wiring only).
// Backpressure: ReqReady low holds the request upstream; MemAck completes memory accesses.
interface mem_lane_unit_if;
  import mem_lane_unit_pkg::*;

  logic              ReqValid;
  logic              ReqReady;
  logic              ReqWrite;
  logic [1:0]        ReqSize;
  logic              ReqSigned;
  logic [DATA_W-1:0] ReqAddr;
  logic [DATA_W-1:0] ReqWData;
  logic              MemEn;
  logic              MemWe;
  logic [BE_W-1:0]   MemBE;
  logic [DATA_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData;
  logic [DATA_W-1:0] MemRData;
  logic              MemAck;
  logic              RespValid;
  logic [DATA_W-1:0] RespRData;
  logic              RespErr;
  logic              Stall;

  // The lane unit itself.
  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, MemRData, MemAck,
    output ReqReady, MemEn, MemWe, MemBE, MemAddr, MemWData, RespValid, RespRData, RespErr, Stall
  );

  // Pipeline plus memory environment around the unit.
  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, MemRData, MemAck,
    input  ReqReady, MemEn, MemWe, MemBE, MemAddr, MemWData, RespValid, RespRData, RespErr, Stall
  );

endinterface

// File: rtl/mem_lane_unit_load_lane_ext.sv
// Picks the addressed byte/half lane out of a read word and zero/sign-extends it.
// Latency: purely combinational.
// Backpressure: none.
module load_lane_ext
  import mem_lane_unit_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        offset,
  input  logic [1:0]        size,
  input  logic              is_signed,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane select then extension; words pass through untouched.
  always_comb begin
    lane_b = rdata[{offset, 3'b000} +: 8];
    lane_h = rdata[{offset[1], 4'b0000} +: 16];
    data   = rdata;
    case (size)
      SIZE_BYTE: data = {{24{is_signed & lane_b[7]}}, lane_b};
      SIZE_HALF: data = {{16{is_signed & lane_h[15]}}, lane_h};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lane_unit.sv
// MEM-stage data-memory access unit: store lane narrowing, load extension, req/ack with timeout.
// Latency: accept -> MemEn next cycle -> RespValid cycle after ack; error without access responds after 1 cycle.
// Backpressure: ReqReady only in IDLE; Stall held while busy; MemEn gives up after TIMEOUT cycles.
module mem_lane_unit
  import mem_lane_unit_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input logic             clk,
  input logic             rst_n,
  mem_lane_unit_if.slave  bus
);

  state_t            state_q, state_d;
  logic              accept, acc_err, timeout;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        off_q, size_q;
  logic              signed_q, write_q;
  logic              we_q;
  logic [BE_W-1:0]   be_q, st_be;
  logic [DATA_W-1:0] maddr_q, wdata_q, st_wdata;
  logic [DATA_W-1:0] rdata_q, ext_data;
  logic              err_q;

  assign accept  = bus.ReqValid && (state_q == ST_IDLE);
  assign acc_err = req_err(bus.ReqSize, bus.ReqAddr[1:0]);
  assign timeout = (cnt_q == CNT_W'(TIMEOUT));

  load_lane_ext u_ext (
    .rdata     (bus.MemRData),
    .offset    (off_q),
    .size      (size_q),
    .is_signed (signed_q),
    .data      (ext_data)
  );

  // State register; async reset drops MemEn immediately since it decodes from state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: ack beats a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = acc_err ? ST_DONE : ST_ACCESS;
      ST_ACCESS: if (bus.MemAck || timeout) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs: handshake decoded from state, bus fields from registers.
  always_comb begin
    bus.ReqReady  = (state_q == ST_IDLE);
    bus.Stall     = (state_q != ST_IDLE);
    bus.MemEn     = (state_q == ST_ACCESS);
    bus.RespValid = (state_q == ST_DONE);
    bus.RespErr   = (state_q == ST_DONE) && err_q;
    bus.RespRData = (state_q == ST_DONE) ? rdata_q : '0;
    bus.MemWe     = we_q;
    bus.MemBE     = be_q;
    bus.MemAddr   = maddr_q;
    bus.MemWData  = wdata_q;
  end

  // Store narrowing from the incoming request; loads enable all lanes with no data.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = '0;
    if (bus.ReqWrite) begin
      case (bus.ReqSize)
        SIZE_BYTE: begin
          st_be    = 4'b0001 << bus.ReqAddr[1:0];
          st_wdata = {4{bus.ReqWData[7:0]}};
        end
        SIZE_HALF: begin
          st_be    = bus.ReqAddr[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{bus.ReqWData[15:0]}};
        end
        default: begin
          st_be    = 4'b1111;
          st_wdata = bus.ReqWData;
        end
      endcase
    end
  end

  // Request latch, wait counter and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      off_q    <= 2'b00;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
      maddr_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      off_q    <= bus.ReqAddr[1:0];
      size_q   <= bus.ReqSize;
      signed_q <= bus.ReqSigned;
      write_q  <= bus.ReqWrite;
      we_q     <= bus.ReqWrite;
      be_q     <= st_be;
      maddr_q  <= {bus.ReqAddr[DATA_W-1:2], 2'b00};
      wdata_q  <= st_wdata;
      cnt_q    <= acc_err ? '0 : CNT_W'(1);
      err_q    <= acc_err;
      rdata_q  <= '0;
    end else if (state_q == ST_ACCESS) begin
      if (bus.MemAck) begin
        rdata_q <= write_q ? '0 : ext_data;
        err_q   <= 1'b0;
        cnt_q   <= '0;
      end else if (timeout) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
        cnt_q   <= '0;
      end else begin
        cnt_q   <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
